// File: rtl/branch_resolve_queue.sv
// In-order queue of fetched branch predictions awaiting resolution.
// Trains the predictor on each resolve and flushes on mispredict.
module branch_resolve_queue #(
  parameter int depth       = 4,
  parameter int pc_width    = 32,
  parameter int count_width = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred,
  input  logic                       alloc_valid,
  input  logic [pc_width-1:0]        alloc_pc,
  output logic                       alloc_ready,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  input  logic [pc_width-1:0]        resolve_pc,
  output logic                       update,
  output logic                       taken,
  output logic                       mispredict,
  output logic [pc_width-1:0]        mispredict_pc,
  output logic [$clog2(depth):0]     occupancy,
  output logic [count_width-1:0]     pred_count,
  output logic [count_width-1:0]     mispred_count,
  output logic                       error
);

  localparam int aw = $clog2(depth);
  localparam int ow = aw + 1;
  localparam logic [ow-1:0] full_occ = ow'(depth);
  localparam logic [count_width-1:0] cmax = '1;

  typedef struct packed {
    logic [pc_width-1:0] pc;
    logic                pred;
  } entry_t;

  entry_t          mem [depth];
  entry_t          head;
  logic [aw-1:0]   wr_ptr;
  logic [aw-1:0]   rd_ptr;
  logic            alloc_fire;
  logic            resolve_fire;
  logic            miss;
  logic            pc_bad;
  logic            empty_res;

  assign alloc_ready  = (occupancy != full_occ);
  assign head         = mem[rd_ptr];
  assign alloc_fire   = alloc_valid & alloc_ready;
  assign resolve_fire = resolve_valid & (occupancy != '0);
  assign miss         = resolve_fire
                      & (resolve_taken != head.pred);
  assign pc_bad       = resolve_fire
                      & (resolve_pc != head.pc);
  assign empty_res    = resolve_valid & (occupancy == '0);

  // Entries need no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      mem[wr_ptr] <= '{pc: alloc_pc, pred: pred};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      update        <= 1'b0;
      taken         <= 1'b0;
      mispredict    <= 1'b0;
      mispredict_pc <= '0;
      pred_count    <= '0;
      mispred_count <= '0;
      error         <= 1'b0;
    end else begin
      update     <= resolve_fire;
      taken      <= resolve_fire & resolve_taken;
      mispredict <= miss;
      if (resolve_fire) begin
        mispredict_pc <= head.pc;
        rd_ptr        <= rd_ptr + 1'b1;
        if (pred_count != cmax) begin
          pred_count <= pred_count + 1'b1;
        end
      end
      if (miss && mispred_count != cmax) begin
        mispred_count <= mispred_count + 1'b1;
      end
      // A mispredict squashes every younger entry, including
      // an allocation arriving in the same cycle.
      if (miss) begin
        occupancy <= '0;
        wr_ptr    <= rd_ptr + 1'b1;
      end else begin
        if (alloc_fire) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        unique case (1'b1)
          alloc_fire & ~resolve_fire:
            occupancy <= occupancy + 1'b1;
          resolve_fire & ~alloc_fire:
            occupancy <= occupancy - 1'b1;
          default:
            occupancy <= occupancy;
        endcase
      end
      if (empty_res | pc_bad) begin
        error <= 1'b1;
      end
    end
  end

endmodule
